// File: rtl/calc1_pkg.sv
// calc1_pkg: shared calc1 port widths, command/response codes and the port-driver state type.
package calc1_pkg;
    localparam int DATA_W = 32;
    localparam int CMD_W  = 4;
    localparam int RESP_W = 2;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

    localparam logic [RESP_W-1:0] RESP_NONE   = 2'd0;
    localparam logic [RESP_W-1:0] RESP_OK     = 2'd1;
    localparam logic [RESP_W-1:0] RESP_ERR    = 2'd2;
    localparam logic [RESP_W-1:0] RESP_UNUSED = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        SEND_OP2,
        WAIT_RESP,
        DONE
    } state_t;
endpackage

// File: rtl/calc1_port_driver.sv
// calc1_port_driver: turns one valid/ready operation into calc1's two-cycle port protocol
// and returns the port response (or a timeout) over a second valid/ready handshake.
module calc1_port_driver
    import calc1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CMD_W-1:0]  req_cmd,
    input  logic [DATA_W-1:0] req_op1,
    input  logic [DATA_W-1:0] req_op2,
    output logic [CMD_W-1:0]  port_cmd,
    output logic [DATA_W-1:0] port_data,
    input  logic [RESP_W-1:0] port_resp,
    input  logic [DATA_W-1:0] port_data_in,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RESP_W-1:0] rsp_resp,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_timeout
);
    state_t              r_state;
    logic [DATA_W-1:0]   r_op2;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_req_ready;
    logic [CMD_W-1:0]    r_port_cmd;
    logic [DATA_W-1:0]   r_port_data;
    logic                r_rsp_valid;
    logic [RESP_W-1:0]   r_rsp_resp;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_timeout;
    logic                w_expired;

    assign w_expired   = r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign req_ready   = r_req_ready;
    assign port_cmd    = r_port_cmd;
    assign port_data   = r_port_data;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_data    = r_rsp_data;
    assign rsp_timeout = r_rsp_timeout;

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_op2         <= '0;
            r_cnt         <= '0;
            r_req_ready   <= 1'b0;
            r_port_cmd    <= '0;
            r_port_data   <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_resp    <= '0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_port_cmd  <= req_cmd;
                        r_port_data <= req_op1;
                        r_op2       <= req_op2;
                        r_state     <= SEND_CMD;
                    end
                end
                SEND_CMD: begin
                    r_port_cmd  <= '0;
                    r_port_data <= r_op2;
                    r_state     <= SEND_OP2;
                end
                SEND_OP2: begin
                    r_port_data <= '0;
                    r_cnt       <= '0;
                    r_state     <= WAIT_RESP;
                end
                WAIT_RESP: begin
                    r_cnt <= r_cnt + 1'b1;
                    // a response arriving on the expiry cycle still beats the timeout
                    if (port_resp != RESP_NONE) begin
                        r_rsp_resp    <= port_resp;
                        r_rsp_data    <= port_data_in;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= DONE;
                    end else if (w_expired) begin
                        r_rsp_resp    <= RESP_NONE;
                        r_rsp_data    <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= DONE;
                    end
                end
                DONE: begin
                    if (r_rsp_valid && rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/calc1_port_driver.md
Name: calc1_port_driver

Overview:
Upstream request sequencer for one calc1 requester port. Accepts a complete operation (command, operand 1, operand 2) from a producer over a valid/ready handshake. Converts it into calc1's two-cycle port protocol, waits for the port's response, and returns result plus status to a consumer over a second valid/ready handshake. One instance per calc1 port; at most one request outstanding per instance.

Parameters:
TIMEOUT_CYCLES, 64, cycles to wait in WAIT_RESP before declaring timeout (range 2..255)
CNT_W, 8, width of the timeout counter

Ports:
c_clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  producer has an operation
req_ready  out  1  driver can accept an operation
req_cmd  in  [0:3]  calc1 command code
req_op1  in  [0:31]  first operand
req_op2  in  [0:31]  second operand
port_cmd  out  [0:3]  to calc1 reqN_cmd_in
port_data  out  [0:31]  to calc1 reqN_data_in
port_resp  in  [0:1]  from calc1 out_respN
port_data_in  in  [0:31]  from calc1 out_dataN
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_resp  out  [0:1]  calc1 response code as received (0 on timeout)
rsp_data  out  [0:31]  calc1 result data (0 on timeout)
rsp_timeout  out  1  no response within TIMEOUT_CYCLES

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, req_ready=0, port_cmd=0, port_data=0, rsp_valid=0, rsp_resp=0, rsp_data=0, rsp_timeout=0, counter=0. Reset mid-operation abandons the request without recovery; the first cycle after release is IDLE.
- All outputs are registered. req_ready=1 only in IDLE.
- IDLE: on req_valid&req_ready, latch cmd/op1/op2 and go to SEND_CMD.
- SEND_CMD (1 cycle): port_cmd=latched cmd, port_data=op1. Go to SEND_OP2.
- SEND_OP2 (1 cycle): port_cmd=0, port_data=op2. Clear counter. Go to WAIT_RESP.
- WAIT_RESP: port_cmd=0, port_data=0; counter increments each cycle.
  - port_resp!=0: capture port_resp and port_data_in into rsp_resp/rsp_data, rsp_timeout=0, rsp_valid=1, go to DONE.
  - Otherwise, when counter reaches TIMEOUT_CYCLES-1: rsp_resp=0, rsp_data=0, rsp_timeout=1, rsp_valid=1, go to DONE.
  - Response and timeout in the same cycle: the response wins.
- DONE: hold rsp_* stable while rsp_ready=0. On rsp_valid&rsp_ready: rsp_valid=0, go to IDLE. req_ready rises the following cycle, so back-to-back requests are spaced at least 4 cycles apart.
- A nonzero port_resp outside WAIT_RESP is ignored.
- No local command checking: cmd 0, 3, 4, 7–15 are forwarded unchanged. calc1 reports errors through resp.
- Minimum request-accept-to-rsp_valid latency: 3 cycles plus calc1 latency.

Decomposition:
- Shared package calc1_pkg holds:
  - Command constants: CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6.
  - Response constants: RESP_NONE=0, RESP_OK=1, RESP_ERR=2, RESP_UNUSED=3.
  - Data width 32, command width 4, response width 2.
  - The state enum (IDLE, SEND_CMD, SEND_OP2, WAIT_RESP, DONE).
- No sub-module is needed. Four instances plus calc1 are wired at the next level up.

Test Plan:
- Add 00000001h + 1FFF_FFFFh, rsp_ready=1 → port_cmd=1 for exactly one cycle with data 1, then 1FFF_FFFFh; rsp_resp=1, rsp_data=2000_0000h, rsp_timeout=0.
- Add FFFF_FFFFh + 00000001h → rsp_resp=2 (overflow). Sub 00000001h − 0000_000Fh → rsp_resp=2 (underflow).
- Cmd 3, op1=1, op2=0 → forwarded unchanged; rsp_resp=2.
- Stub port_resp held at 0, TIMEOUT_CYCLES=8 → rsp_valid rises 8 cycles after entering WAIT_RESP; rsp_timeout=1, rsp_resp=0, rsp_data=0.
- Hold rsp_ready=0 for 10 cycles after a successful add (1+1) → rsp_data stays 2 and req_ready stays 0; releasing rsp_ready gives IDLE and req_ready=1 one cycle later.
- Assert reset=0 during WAIT_RESP → all outputs 0 immediately (no clock edge needed); after release, a new add 2+3 returns rsp_data=5, rsp_resp=1.
